// File: rtl/fir_tap_sched_if.sv
// Window-in / result-out stream bundle for the 3x3 FIR tap scheduler.
// The master modport is the upstream window source plus the downstream sink; the slave modport is the scheduler.
interface fir_tap_sched_if #(
  parameter int TAPS  = 9,
  parameter int PW    = 8,
  parameter int ACCW  = 20
);
  logic [TAPS*PW-1:0] in_win;
  logic               in_valid;
  logic               in_ready;
  logic [ACCW-1:0]    out_data;
  logic               out_valid;
  logic               out_ready;

  modport master (
    output in_win,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready
  );

  modport slave (
    input  in_win,
    input  in_valid,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready
  );
endinterface

// File: rtl/fir_tap_sched.sv
// Walks one latched 3x3 window through a single shared LUT multiplier, one tap per cycle,
// registering each product and summing all taps into one unsigned result per window.
module fir_tap_sched #(
  parameter int TAPS  = 9,
  parameter int PW    = 8,
  parameter int PRODW = 16,
  parameter int ACCW  = 20
) (
  input  logic              clk,
  input  logic              rst_n,
  fir_tap_sched_if.slave    s,
  output logic [PW-1:0]     mult_x,
  output logic [3:0]        mult_bank,
  output logic              mult_en,
  input  logic [PRODW-1:0]  mult_ax,
  output logic              busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [3:0] LAST_TAP = 4'(TAPS - 1);

  logic [1:0]       state;
  logic [3:0]       tap_p0;
  logic [PW-1:0]    win_p0 [TAPS];
  logic [PRODW-1:0] prod_p1;
  logic             vld_p1;
  logic [ACCW-1:0]  acc_p2;

  function automatic logic [ACCW-1:0] zext_prod(input logic [PRODW-1:0] p);
    return {{(ACCW-PRODW){1'b0}}, p};
  endfunction

  // Stage 0: window capture; data only, so no reset
  always_ff @(posedge clk) begin
    if (state == IDLE && s.in_valid) begin
      for (int k = 0; k < TAPS; k++) begin
        win_p0[k] <= s.in_win[k*PW +: PW];
      end
    end
  end

  // Operand selection; the multiplier answers combinationally in the same cycle
  always_comb begin
    mult_en   = 1'b0;
    mult_x    = '0;
    mult_bank = '0;
    if (state == RUN) begin
      mult_en   = 1'b1;
      mult_x    = win_p0[tap_p0];
      mult_bank = tap_p0;
    end
  end

  // Stage 1: product register; Stage 2: accumulator (lags the product by one cycle)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tap_p0  <= '0;
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      acc_p2  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s.in_valid) begin
            acc_p2 <= '0;
            tap_p0 <= '0;
            vld_p1 <= 1'b0;
            state  <= RUN;
          end
        end
        RUN: begin
          prod_p1 <= mult_ax;
          vld_p1  <= 1'b1;
          if (vld_p1) begin
            acc_p2 <= acc_p2 + zext_prod(prod_p1);
          end
          if (tap_p0 == LAST_TAP) begin
            tap_p0 <= '0;
            state  <= DRAIN;
          end else begin
            tap_p0 <= tap_p0 + 4'd1;
          end
        end
        DRAIN: begin
          // Fold in the last tap's product, still waiting in the product register
          acc_p2 <= acc_p2 + zext_prod(prod_p1);
          vld_p1 <= 1'b0;
          state  <= DONE;
        end
        DONE: begin
          if (s.out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign s.in_ready  = (state == IDLE);
  assign s.out_valid = (state == DONE);
  assign s.out_data  = acc_p2;
  assign busy        = (state == RUN) || (state == DRAIN);

endmodule

// File: doc/fir_tap_sched.md
Name: fir_tap_sched

Overview:
- Sequences one 3x3 2D-FIR output pixel through a single shared dual-port LUT multiplier, one tap per cycle.
- Latches a 9-pixel window and drives the multiplier operand plus coefficient-bank select, where bank equals tap index.
- Registers each 16-bit product and accumulates all nine into a 20-bit result.
- Sits between the line-buffer/window generator upstream and the output pixel stage downstream.

Parameters:
TAPS, 9, taps per output pixel (window size)
PW, 8, pixel width in bits
PRODW, 16, multiplier product width
ACCW, 20, accumulator/result width; must be >= PRODW + ceil(log2(TAPS))

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_win  input  TAPS*PW  packed window, tap k at bits [k*PW +: PW], tap 0 = top-left, raster order
in_valid  input  1  window valid
in_ready  output  1  block can accept a window
mult_x  output  PW  operand to multiplier (x)
mult_bank  output  4  coefficient LUT bank select (= tap index)
mult_en  output  1  multiplier/LUT read enable
mult_ax  input  PRODW  product from multiplier; combinational response to mult_x/mult_bank in the same cycle
out_data  output  ACCW  accumulated filter result
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
busy  output  1  high in RUN or DRAIN

Behaviour:
- Reset (async, rst_n=0): state=IDLE; tap counter=0; acc=0; prod_r=0; prod_v=0. Output values:
  - in_ready=1 (combinational from IDLE).
  - out_valid=0, out_data=0.
  - mult_en=0, mult_x=0, mult_bank=0.
  - busy=0.
- Reset mid-operation discards the window and partial sum; no output is produced for it.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1 at a clock edge: latch in_win, acc<=0, tap<=0, prod_v<=0, go to RUN.
- RUN:
  - mult_en=1; mult_x=win[tap]; mult_bank=tap.
  - Each edge: prod_r<=mult_ax, prod_v<=1, tap<=tap+1.
  - If prod_v=1: acc<=acc+prod_r (zero-extended to ACCW).
  - On the edge where tap==TAPS-1: go to DRAIN; tap<=0 (no wrap beyond TAPS-1).
- DRAIN:
  - mult_en=0, mult_x=0, mult_bank=0.
  - Edge: acc<=acc+prod_r, prod_v<=0, go to DONE.
- DONE:
  - out_valid=1; out_data=acc, held stable while out_ready=0.
  - Edge with out_ready=1: go to IDLE; out_valid deasserts next cycle.
- Latency: out_valid rises exactly TAPS+1 = 10 cycles after the acceptance edge. Throughput is one window per 12 cycles with out_ready tied high.
- in_ready is 0 in RUN/DRAIN/DONE. in_valid in those states is ignored; it is not queued.
- Arithmetic is unsigned; no overflow is possible with the default widths (9*65025 = 585225 < 2^20).
- out_data is driven from acc in all states. It is meaningful only while out_valid=1.
- mult_bank width is fixed at 4 bits; TAPS <= 16.

Test Plan:
1. Bench multiplier model mult_ax = coef[bank]*x, coef[k]=k+1; window all pixels=1, out_ready=1 -> out_data=45 (0x0002D), out_valid 10 cycles after acceptance, one cycle wide, in_ready back to 1 next cycle.
2. coef all 255, pixels all 255 -> out_data=585225 (0x8EE09), no truncation; mult_bank sequence 0..8 on consecutive cycles, mult_en high exactly 9 cycles.
3. Pixels k*16 (k=0..8), coef[k]=2 -> out_data=1152; mult_x shows 0x00,0x10,...,0x80 in order.
4. out_ready held low 5 cycles in DONE while in_valid=1 with a new window -> out_data stable, in_ready=0, new window not accepted. Then out_ready=1 -> IDLE; the new window is accepted only if in_valid is still high in IDLE.
5. rst_n pulsed low during RUN at tap=4 -> all outputs return to reset values immediately (async). After release, a fresh all-ones window with coef=k+1 yields 45, with no residue from the aborted sum.
6. Two back-to-back windows with in_valid held high, out_ready=1 -> two results (45, then 90 with pixels=2), accepted 12 cycles apart; out_valid never high in two consecutive cycles.
